mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 179 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-port initiator for the unified RAM: one load/store at a time, checked for
// funct3 legality, alignment and range, with a registered, held response.
module mem_access_unit #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_error,
    output logic [31:0] mem_read_address,
    output logic [2:0]  mem_size_and_sign,
    input  logic [31:0] mem_read_data,
    input  logic        mem_illegal_read_address,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic        mem_illegal_write_address
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WSETTLE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_MISALIGN  = 2'b01;
    localparam logic [1:0] ERR_ACCESS    = 2'b10;
    localparam logic [1:0] ERR_FUNCT3    = 2'b11;

    state_t      state_reg, state_next;
    logic        write_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] address_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;
    logic [1:0]  error_reg;

    logic [1:0]  bytes_m1;
    logic [32:0] end_address;
    logic        illegal_funct3;
    logic        misaligned;
    logic        out_of_range;
    logic [1:0]  check_error;
    logic [31:0] load_data;

    // Legality checks operate on the captured request, so they are stable in ISSUE.
    always_comb begin
        bytes_m1 = 2'd3;
        case (funct3_reg[1:0])
            2'b00:   bytes_m1 = 2'd0;
            2'b01:   bytes_m1 = 2'd1;
            default: bytes_m1 = 2'd3;
        endcase

        if (write_reg)
            illegal_funct3 = funct3_reg[2] || (funct3_reg[1:0] == 2'b11);
        else
            illegal_funct3 = (funct3_reg == 3'b011) || (funct3_reg[2:1] == 2'b11);

        misaligned = ((funct3_reg[1:0] == 2'b01) && address_reg[0]) ||
                     ((funct3_reg[1:0] == 2'b10) && (address_reg[1:0] != 2'b00));

        // 33-bit sum so an address that wraps past 2^32 is still out of range
        end_address  = {1'b0, address_reg} + {31'd0, bytes_m1};
        out_of_range = end_address >= 33'(MEM_BYTES);

        if (illegal_funct3)
            check_error = ERR_FUNCT3;
        else if (misaligned)
            check_error = ERR_MISALIGN;
        else if (out_of_range)
            check_error = ERR_ACCESS;
        else
            check_error = ERR_OK;
    end

    always_comb begin
        load_data = 32'd0;
        case (funct3_reg)
            3'b000:  load_data = {{24{mem_read_data[7]}}, mem_read_data[7:0]};
            3'b001:  load_data = {{16{mem_read_data[15]}}, mem_read_data[15:0]};
            3'b010:  load_data = mem_read_data;
            3'b100:  load_data = {24'd0, mem_read_data[7:0]};
            3'b101:  load_data = {16'd0, mem_read_data[15:0]};
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        state_next       = state_reg;
        mem_write_enable = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid)
                    state_next = ISSUE;
            end
            ISSUE: begin
                if (check_error != ERR_OK) begin
                    state_next = RESP;
                end else if (write_reg) begin
                    mem_write_enable = 1'b1;
                    state_next       = WSETTLE;
                end else begin
                    state_next = RESP;
                end
            end
            WSETTLE: state_next = RESP;
            RESP: begin
                if (resp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            write_reg   <= 1'b0;
            funct3_reg  <= 3'd0;
            address_reg <= 32'd0;
            wdata_reg   <= 32'd0;
            rdata_reg   <= 32'd0;
            error_reg   <= ERR_OK;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg   <= req_write;
                        funct3_reg  <= req_funct3;
                        address_reg <= req_address;
                        wdata_reg   <= req_wdata;
                    end
                end
                ISSUE: begin
                    if (check_error != ERR_OK) begin
                        rdata_reg <= 32'd0;
                        error_reg <= check_error;
                    end else if (write_reg) begin
                        rdata_reg <= 32'd0;
                        error_reg <= ERR_OK;
                    end else if (mem_illegal_read_address) begin
                        rdata_reg <= 32'd0;
                        error_reg <= ERR_ACCESS;
                    end else begin
                        rdata_reg <= load_data;
                        error_reg <= ERR_OK;
                    end
                end
                WSETTLE: begin
                    if (mem_illegal_write_address)
                        error_reg <= ERR_ACCESS;
                end
                default: ;
            endcase
        end
    end

    assign req_ready         = (state_reg == IDLE);
    assign resp_valid        = (state_reg == RESP);
    assign resp_rdata        = rdata_reg;
    assign resp_error        = error_reg;
    assign mem_read_address  = address_reg;
    assign mem_write_address = address_reg;
    assign mem_write_data    = wdata_reg;
    assign mem_size_and_sign = funct3_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-addressed RAM model attached
// to the data port and hand-computed expected responses.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_address = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_error;
    logic [31:0] mem_read_address;
    logic [2:0]  mem_size_and_sign;
    logic [31:0] mem_read_data;
    logic        mem_illegal_read_address;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic        mem_illegal_write_address = 1'b0;

    int checks = 0;
    int errors = 0;
    int write_count = 0;
    logic rd_fault_force = 1'b0;
    logic wr_fault_force = 1'b0;
    logic [7:0] ram [0:4095];

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(4096)) dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .req_valid                 (req_valid),
        .req_ready                 (req_ready),
        .req_write                 (req_write),
        .req_funct3                (req_funct3),
        .req_address               (req_address),
        .req_wdata                 (req_wdata),
        .resp_valid                (resp_valid),
        .resp_ready                (resp_ready),
        .resp_rdata                (resp_rdata),
        .resp_error                (resp_error),
        .mem_read_address          (mem_read_address),
        .mem_size_and_sign         (mem_size_and_sign),
        .mem_read_data             (mem_read_data),
        .mem_illegal_read_address  (mem_illegal_read_address),
        .mem_write_address         (mem_write_address),
        .mem_write_data            (mem_write_data),
        .mem_write_enable          (mem_write_enable),
        .mem_illegal_write_address (mem_illegal_write_address)
    );

    // RAM model: combinational little-endian read, byte-lane write on the edge.
    always_comb begin
        mem_read_data = {ram[12'(mem_read_address + 32'd3)], ram[12'(mem_read_address + 32'd2)],
                         ram[12'(mem_read_address + 32'd1)], ram[12'(mem_read_address)]};
        mem_illegal_read_address = rd_fault_force;
    end

    always @(posedge clk) begin
        if (mem_write_enable) begin
            write_count <= write_count + 1;
            mem_illegal_write_address <= wr_fault_force;
            ram[12'(mem_write_address)] <= mem_write_data[7:0];
            if (mem_size_and_sign[1:0] != 2'b00)
                ram[12'(mem_write_address + 32'd1)] <= mem_write_data[15:8];
            if (mem_size_and_sign[1:0] == 2'b10) begin
                ram[12'(mem_write_address + 32'd2)] <= mem_write_data[23:16];
                ram[12'(mem_write_address + 32'd3)] <= mem_write_data[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_data, input logic [1:0] exp_err,
                          input int exp_lat, input int exp_writes);
        int wc0;
        int lat;
        @(negedge clk);
        check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_address = a; req_wdata = d;
        wc0 = write_count;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".data"}, resp_rdata, exp_data);
        check({tag, ".err"}, {30'd0, resp_error}, {30'd0, exp_err});
        check({tag, ".writes"}, 32'(write_count - wc0), 32'(exp_writes));
        $display("%s: w=%0d f3=%0d addr=0x%08h data=0x%08h err=%0d lat=%0d",
                 tag, w, f3, a, resp_rdata, resp_error, lat);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, ".done"}, {30'd0, resp_valid, req_ready}, 32'b01);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;

        #2;
        check("rst.ready", {31'd0, req_ready}, 32'd1);
        check("rst.valid", {31'd0, resp_valid}, 32'd0);
        check("rst.rdata", resp_rdata, 32'd0);
        check("rst.err", {30'd0, resp_error}, 32'd0);
        check("rst.memout", {mem_read_address | mem_write_address | mem_write_data,
                             1'b0}, 33'd0);
        check("rst.we_size", {28'd0, mem_write_enable, mem_size_and_sign}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset during ISSUE of a store: strobe must drop immediately.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_address = 32'h100; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstmid.we_before", {31'd0, mem_write_enable}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rstmid.we_after", {31'd0, mem_write_enable}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rstmid.state", {30'd0, req_ready, resp_valid}, 32'b10);
        check("rstmid.nowrite", 32'(write_count), 32'd0);
        $display("rstmid: reset during store ISSUE, writes=%0d", write_count);

        do_req("sw10",  1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        2'b00, 3, 1);
        do_req("lw10",  1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 2'b00, 2, 0);
        do_req("sb21",  1'b1, 3'b000, 32'h21,  32'h80,       32'h0,        2'b00, 3, 1);
        do_req("lb21",  1'b0, 3'b000, 32'h21,  32'h0,        32'hFFFFFF80, 2'b00, 2, 0);
        do_req("lbu21", 1'b0, 3'b100, 32'h21,  32'h0,        32'h00000080, 2'b00, 2, 0);
        do_req("sh22",  1'b1, 3'b001, 32'h22,  32'h8001,     32'h0,        2'b00, 3, 1);
        do_req("lh22",  1'b0, 3'b001, 32'h22,  32'h0,        32'hFFFF8001, 2'b00, 2, 0);
        do_req("lhu22", 1'b0, 3'b101, 32'h22,  32'h0,        32'h00008001, 2'b00, 2, 0);
        do_req("lw20",  1'b0, 3'b010, 32'h20,  32'h0,        32'h80018000, 2'b00, 2, 0);
        do_req("lw13",  1'b0, 3'b010, 32'h13,  32'h0,        32'h0,        2'b01, 2, 0);
        do_req("sh11",  1'b1, 3'b001, 32'h11,  32'h1234,     32'h0,        2'b01, 2, 0);
        do_req("swffc", 1'b1, 3'b010, 32'hFFC, 32'h11223344, 32'h0,        2'b00, 3, 1);
        do_req("lbfff", 1'b0, 3'b000, 32'hFFF, 32'h0,        32'h00000011, 2'b00, 2, 0);
        do_req("swffe", 1'b1, 3'b010, 32'hFFE, 32'h5,        32'h0,        2'b01, 2, 0);
        do_req("shfff", 1'b1, 3'b001, 32'hFFF, 32'h5,        32'h0,        2'b01, 2, 0);
        do_req("sb1000",1'b1, 3'b000, 32'h1000,32'h5,        32'h0,        2'b10, 2, 0);
        do_req("lwwrap",1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,   32'h0,        2'b10, 2, 0);
        do_req("lf3_3", 1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        2'b11, 2, 0);
        do_req("sf3_4", 1'b1, 3'b100, 32'h10,  32'h5,        32'h0,        2'b11, 2, 0);
        do_req("lf3_6", 1'b0, 3'b110, 32'h13,  32'h0,        32'h0,        2'b11, 2, 0);

        rd_fault_force = 1'b1;
        do_req("lwrdf", 1'b0, 3'b010, 32'h10,  32'h0,        32'h0,        2'b10, 2, 0);
        rd_fault_force = 1'b0;
        wr_fault_force = 1'b1;
        do_req("swwrf", 1'b1, 3'b010, 32'h40,  32'h77,       32'h0,        2'b10, 3, 1);
        wr_fault_force = 1'b0;

        // Backpressure: response must hold for five cycles with resp_ready low.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp.valid", {31'd0, resp_valid}, 32'd1);
            check("bp.ready", {31'd0, req_ready}, 32'd0);
            check("bp.data", resp_rdata, 32'hDEADBEEF);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("bp.release", {30'd0, req_ready, resp_valid}, 32'b10);
        $display("bp: held 5 cycles, data=0x%08h", resp_rdata);

        // Back-to-back loads with req_valid and resp_ready held high.
        begin
            int nresp;
            nresp = 0;
            req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h10;
            resp_ready = 1'b1;
            for (int i = 0; i < 9; i++) begin
                @(negedge clk);
                if (resp_valid) nresp++;
            end
            req_valid = 1'b0;
            resp_ready = 1'b0;
            check("b2b.count", 32'(nresp), 32'd3);
            $display("b2b: %0d responses in 9 cycles", nresp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
